// File: rtl/ftdi_fifo_bridge.sv
// ftdi_fifo_bridge
// Bridge between fabric byte streams and an FTDI FT2232-class chip in
// asynchronous 245 FIFO mode. Outbound bytes are buffered in a TX FIFO and
// written with WR#; inbound bytes are read with RD# into a show-ahead RX FIFO.
// Optional feature macro: FTDI_BRIDGE_RR_ARB_EN (round-robin read/write
// arbitration; fixed read priority when undefined).
//
// Ports:
//   clock, reset_n     sole clock, async active-low reset
//   clear              synchronous flush of both FIFOs and the FSM
//   rxf_n, txe_n       FTDI status (pre-synchronised, active-low)
//   adbus_in/out/oe    pad data in, pad data out, pad output enable
//   ftdi_rd_n/wr_n     RD#/WR# strobes
//   rd_en, wr_en       permit reads / writes from/to the FTDI
//   tx_data/valid/ready outbound byte stream into the TX FIFO
//   rx_data/valid/ready inbound byte stream out of the RX FIFO
//   tx_level, rx_level FIFO occupancies (0..DEPTH)
module ftdi_fifo_bridge #(
  parameter int unsigned TX_DEPTH = 16,
  parameter int unsigned RX_DEPTH = 64,
  parameter int unsigned WR_SETUP = 1,
  parameter int unsigned WR_PULSE = 2,
  parameter int unsigned RD_PULSE = 2
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        clear,
  input  logic                        rxf_n,
  input  logic                        txe_n,
  input  logic [7:0]                  adbus_in,
  output logic [7:0]                  adbus_out,
  output logic                        adbus_oe,
  output logic                        ftdi_rd_n,
  output logic                        ftdi_wr_n,
  input  logic                        rd_en,
  input  logic                        wr_en,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(TX_DEPTH):0]   tx_level,
  output logic [$clog2(RX_DEPTH):0]   rx_level
);

  localparam int unsigned TX_AW   = $clog2(TX_DEPTH);
  localparam int unsigned TX_LW   = TX_AW + 1;
  localparam int unsigned RX_AW   = $clog2(RX_DEPTH);
  localparam int unsigned RX_LW   = RX_AW + 1;
  localparam int unsigned CNT_MAX0 = (WR_SETUP > WR_PULSE) ? WR_SETUP : WR_PULSE;
  localparam int unsigned CNT_MAX  = (CNT_MAX0 > RD_PULSE) ? CNT_MAX0 : RD_PULSE;
  localparam int unsigned CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_SET  = 3'd1;
  localparam logic [2:0] ST_WR_STB  = 3'd2;
  localparam logic [2:0] ST_WR_HOLD = 3'd3;
  localparam logic [2:0] ST_RD_STB  = 3'd4;
  localparam logic [2:0] ST_RD_REC  = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_n_q, wr_n_d;
  logic             rd_n_q, rd_n_d;
  logic             oe_q, oe_d;
  logic [7:0]       dout_q, dout_d;

  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [TX_LW-1:0] tx_level_q, tx_level_d;
  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [RX_LW-1:0] rx_level_q, rx_level_d;

  logic tx_push, tx_pop, rx_push, rx_pop;
  logic rd_elig, wr_elig, pick_rd;

  assign tx_ready = (tx_level_q != TX_LW'(TX_DEPTH));
  assign rx_valid = (rx_level_q != '0);
  assign rx_data  = rx_valid ? rx_mem[rx_rptr_q] : 8'h00;
  assign tx_level = tx_level_q;
  assign rx_level = rx_level_q;

  assign adbus_out = dout_q;
  assign adbus_oe  = oe_q;
  assign ftdi_rd_n = rd_n_q;
  assign ftdi_wr_n = wr_n_q;

  // clear overrides any push or pop in the same cycle
  assign tx_push = tx_valid && tx_ready && !clear;
  assign rx_pop  = rx_valid && rx_ready && !clear;

  assign rd_elig = rd_en && !rxf_n && (rx_level_q != RX_LW'(RX_DEPTH));
  assign wr_elig = wr_en && !txe_n && (tx_level_q != '0);

`ifdef FTDI_BRIDGE_RR_ARB_EN
  logic last_wr_q, last_wr_d;

  // on contention the direction not served last wins
  assign pick_rd = rd_elig && (!wr_elig || last_wr_q);

  // last-served flag updates on transfer start; clear restores "write"
  always_comb begin
    last_wr_d = last_wr_q;
    if (clear) begin
      last_wr_d = 1'b1;
    end else if (state_q == ST_IDLE && state_d == ST_RD_STB) begin
      last_wr_d = 1'b0;
    end else if (state_q == ST_IDLE && state_d == ST_WR_SET) begin
      last_wr_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) last_wr_q <= 1'b1;
    else          last_wr_q <= last_wr_d;
  end
`else
  assign pick_rd = rd_elig;
`endif

  // transfer FSM: one shared down-counter times WR_SET, WR_STB and RD_STB
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tx_pop  = 1'b0;
    rx_push = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_rd) begin
          state_d = ST_RD_STB;
          cnt_d   = CNT_W'(RD_PULSE - 1);
        end else if (wr_elig) begin
          state_d = ST_WR_SET;
          cnt_d   = CNT_W'(WR_SETUP - 1);
        end
      end
      ST_WR_SET: begin
        if (cnt_q == '0) begin
          state_d = ST_WR_STB;
          cnt_d   = CNT_W'(WR_PULSE - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WR_STB: begin
        if (cnt_q == '0) begin
          state_d = ST_WR_HOLD;
          tx_pop  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WR_HOLD: state_d = ST_IDLE;
      ST_RD_STB: begin
        if (cnt_q == '0) begin
          state_d = ST_RD_REC;
          rx_push = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RD_REC: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (clear) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      tx_pop  = 1'b0;
      rx_push = 1'b0;
    end
  end

  // pad outputs are registered from the next state so they align with it
  always_comb begin
    wr_n_d = (state_d != ST_WR_STB);
    rd_n_d = (state_d != ST_RD_STB);
    oe_d   = (state_d == ST_WR_SET) || (state_d == ST_WR_STB) ||
             (state_d == ST_WR_HOLD);
    dout_d = 8'h00;
    if (state_d == ST_WR_SET && state_q == ST_IDLE) begin
      dout_d = tx_mem[tx_rptr_q];
    end else if (oe_d) begin
      dout_d = dout_q;
    end
  end

  // TX FIFO pointers and occupancy
  always_comb begin
    tx_wptr_d  = tx_wptr_q;
    tx_rptr_d  = tx_rptr_q;
    tx_level_d = tx_level_q;
    if (clear) begin
      tx_wptr_d  = '0;
      tx_rptr_d  = '0;
      tx_level_d = '0;
    end else begin
      if (tx_push) tx_wptr_d = tx_wptr_q + TX_AW'(1);
      if (tx_pop)  tx_rptr_d = tx_rptr_q + TX_AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_level_d = tx_level_q + TX_LW'(1);
        2'b01:   tx_level_d = tx_level_q - TX_LW'(1);
        default: tx_level_d = tx_level_q;
      endcase
    end
  end

  // RX FIFO pointers and occupancy
  always_comb begin
    rx_wptr_d  = rx_wptr_q;
    rx_rptr_d  = rx_rptr_q;
    rx_level_d = rx_level_q;
    if (clear) begin
      rx_wptr_d  = '0;
      rx_rptr_d  = '0;
      rx_level_d = '0;
    end else begin
      if (rx_push) rx_wptr_d = rx_wptr_q + RX_AW'(1);
      if (rx_pop)  rx_rptr_d = rx_rptr_q + RX_AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_level_d = rx_level_q + RX_LW'(1);
        2'b01:   rx_level_d = rx_level_q - RX_LW'(1);
        default: rx_level_d = rx_level_q;
      endcase
    end
  end

  // FIFO storage; contents need no reset as levels gate visibility
  always_ff @(posedge clock) begin
    if (tx_push) tx_mem[tx_wptr_q] <= tx_data;
    if (rx_push) rx_mem[rx_wptr_q] <= adbus_in;
  end

  // state and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wr_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      oe_q       <= 1'b0;
      dout_q     <= 8'h00;
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_level_q <= '0;
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_level_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_n_q     <= wr_n_d;
      rd_n_q     <= rd_n_d;
      oe_q       <= oe_d;
      dout_q     <= dout_d;
      tx_wptr_q  <= tx_wptr_d;
      tx_rptr_q  <= tx_rptr_d;
      tx_level_q <= tx_level_d;
      rx_wptr_q  <= rx_wptr_d;
      rx_rptr_q  <= rx_rptr_d;
      rx_level_q <= rx_level_d;
    end
  end

endmodule

// File: doc/ftdi_fifo_bridge.md
# ftdi_fifo_bridge

Parametrised bridge between the FPGA fabric and an FTDI FT2232-class chip in asynchronous 245 FIFO mode. It buffers outbound and inbound bytes in internal FIFOs, and generates the RD#/WR# strobes with programmable setup and pulse widths. It arbitrates between pending reads and writes, and presents valid/ready byte streams to the link logic. It sits between the USB pins and the laser link framing logic.

## Interface
- `TX_DEPTH`, default 16: outbound FIFO depth in bytes; power of two, ≥2.
- `RX_DEPTH`, default 64: inbound FIFO depth in bytes; power of two, ≥2.
- `WR_SETUP`, default 1: cycles data is driven before WR# falls; ≥1.
- `WR_PULSE`, default 2: cycles WR# is held low; ≥1.
- `RD_PULSE`, default 2: cycles RD# is held low; ≥1. Data is sampled on the last cycle.
- `clock`, in, 1: sole clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `clear`, in, 1: synchronous flush of both FIFOs and the FSM.
- `rxf_n`, in, 1: FTDI has data to read, active-low. Pre-synchronised by the caller.
- `txe_n`, in, 1: FTDI can accept a byte, active-low. Pre-synchronised by the caller.
- `adbus_in`, in, 8: pad input data.
- `adbus_out`, out, 8: pad output data.
- `adbus_oe`, out, 1: pad output enable.
- `ftdi_rd_n`, out, 1: RD# strobe.
- `ftdi_wr_n`, out, 1: WR# strobe.
- `rd_en`, in, 1: permits reads from the FTDI.
- `wr_en`, in, 1: permits writes to the FTDI.
- `tx_data`, in, 8: outbound byte.
- `tx_valid`, in, 1: outbound byte valid.
- `tx_ready`, out, 1: outbound FIFO can accept a byte.
- `rx_data`, out, 8: inbound byte at the FIFO head.
- `rx_valid`, out, 1: inbound byte valid.
- `rx_ready`, in, 1: consumer accepts the inbound byte.
- `tx_level`, out, $clog2(TX_DEPTH)+1: outbound FIFO occupancy.
- `rx_level`, out, $clog2(RX_DEPTH)+1: inbound FIFO occupancy.

## Operation
- FIFO push: `tx_valid && tx_ready` pushes `tx_data`. `tx_ready = tx_level != TX_DEPTH`. There is no bypass of a full FIFO, even if a pop happens in the same cycle.
- FIFO pop: `rx_valid && rx_ready` pops. The RX FIFO is show-ahead: `rx_data` is valid whenever `rx_valid` is high.
- FSM states: IDLE, WR_SET, WR_STB, WR_HOLD, RD_STB, RD_REC.
- Read eligible: `rd_en && !rxf_n && rx_level != RX_DEPTH`.
- Write eligible: `wr_en && !txe_n && tx_level != 0`.
- IDLE: moves to RD_STB or WR_SET when eligible, following the arbitration rule in Configuration.
- WR_SET: `adbus_oe=1`, `adbus_out` = TX head, `ftdi_wr_n=1`. Lasts WR_SETUP cycles, then WR_STB.
- WR_STB: `adbus_oe=1`, `ftdi_wr_n=0`, data held. Lasts WR_PULSE cycles. The TX FIFO pops on the last cycle. Next state is WR_HOLD.
- WR_HOLD: 1 cycle, `adbus_oe=1`, `ftdi_wr_n=1`, data held. Next state is IDLE.
- RD_STB: `ftdi_rd_n=0`, `adbus_oe=0`. Lasts RD_PULSE cycles. `adbus_in` is pushed into the RX FIFO on the last cycle. Next state is RD_REC.
- RD_REC: 1 cycle, `ftdi_rd_n=1`, for FTDI RD# inactive time. Next state is IDLE.
- A single shared down-counter, loaded on each state entry, times WR_SET, WR_STB and RD_STB.
- Strobe lines: `ftdi_rd_n` and `ftdi_wr_n` are never low together. `adbus_oe` is never high while `ftdi_rd_n` is low.
- Outside the write states: `adbus_out` = 0 and `adbus_oe` = 0.
- `rd_en`, `wr_en`, `rxf_n` and `txe_n` are evaluated only in IDLE. Deasserting them mid-transfer does not abort the transfer.
- `clear`, or `reset_n` low, while mid-transfer:
  - all strobes go inactive (`ftdi_rd_n=1`, `ftdi_wr_n=1`, `adbus_oe=0`);
  - both FIFOs empty;
  - the in-flight byte is discarded.
- `clear` takes effect at the next edge and overrides a simultaneous push or pop.

## Timing
- Values on reset and clear:
  - FSM: IDLE.
  - `ftdi_rd_n=1`, `ftdi_wr_n=1`, `adbus_oe=0`, `adbus_out=0`.
  - `tx_ready=1`, `rx_valid=0`, `rx_data=0`.
  - `tx_level=0`, `rx_level=0`.
  - Arbitration last-served flag: write.
- All outputs are registered or decoded from registered state only. There is no combinational path from `rxf_n` or `txe_n` to the strobes.
- Push at edge e into an empty TX FIFO (with `wr_en=1`, `txe_n=0`):
  - WR_SET is entered at e+1;
  - `ftdi_wr_n` falls at e+1+WR_SETUP;
  - `ftdi_wr_n` rises at e+1+WR_SETUP+WR_PULSE.
- Write transaction length: WR_SETUP+WR_PULSE+2 cycles, IDLE to IDLE.
- Read transaction length: RD_PULSE+2 cycles, IDLE to IDLE.
- An RX byte captured at edge s has `rx_valid=1` from s (visible in the cycle after s).
- Levels update on the edge following a push or pop. A simultaneous push and pop leaves the level unchanged.
- FIFO pointers wrap modulo depth. The levels count 0..DEPTH inclusive.

## Configuration
- `FTDI_BRIDGE_RR_ARB_EN` defined:
  - when both reads and writes are eligible in IDLE, the one not served last wins;
  - a 1-bit last-served flag is updated on entry to RD_STB or WR_SET.
- `FTDI_BRIDGE_RR_ARB_EN` undefined: fixed read priority; the flag is not built.

## Test plan
- Reset: hold `reset_n=0`, then release → all outputs at the reset values above; FSM in IDLE.
- Single write: push 0xA5 with WR_SETUP=1, WR_PULSE=2, `txe_n=0` → `adbus_out=0xA5` with `adbus_oe=1` from e+1; `ftdi_wr_n` low for exactly 2 cycles starting e+2; `tx_level` back to 0.
- Read fill: `rxf_n=0`, `rd_en=1`, `rx_ready=0`, bytes 0x00..0x3F on `adbus_in` (RX_DEPTH=64) → 64 RD# pulses, then no further RD#; `rx_level=64`. Draining yields 0x00..0x3F in order.
- Arbitration: 4 bytes queued for TX, `rxf_n=0`, both enables high → with the macro, RD/WR alternate starting with RD; without it, all reads precede writes until `rxf_n=1`.
- Mid-strobe clear: assert `clear` during the 2nd cycle of WR_STB → `ftdi_wr_n=1` and `adbus_oe=0` next cycle; `tx_level=0`; no further strobes.
- Wrap and full: push 16 bytes with `txe_n=1` → `tx_ready=0`. A 17th push is ignored. Releasing `txe_n` emits all 16 bytes in order; pointers wrap correctly on a second batch of 16.
